// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide sequencer for the E stage of the MIPS pipeline.
// It owns the HI/LO registers. A mult/div result is computed in its start
// cycle and held in pending registers. It is then committed after a fixed
// latency, which a 4-bit down-counter models. While the counter runs, the
// block raises busy so the hazard unit can hold MDU instructions in D.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_fuc,
  input  logic        E_valid,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] E_md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;

  logic        is_r, dec_mul, dec_div, dec_sgn;
  logic        dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
  logic [63:0] mul_res, div_res;

  // Full 64-bit product. Signed operands are sign-extended to 64 bits, so
  // the low 64 bits of the unsigned product are the signed product.
  function automatic logic [63:0] mul_full(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
    logic [63:0] ae, be;
    ae = {{32{sgn & a[31]}}, a};
    be = {{32{sgn & b[31]}}, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes, so
  // 0x80000000 / -1 wraps back to 0x80000000 with a zero remainder. A zero
  // divisor yields 0; the caller marks that result as not committable.
  function automatic logic [63:0] div_full(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
    logic        neg_a, neg_b;
    logic [31:0] ma, mb, q, r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma = neg_a ? (32'd0 - a) : a;
    mb = neg_b ? (32'd0 - b) : b;
    if (mb == 32'd0) return 64'd0;
    q = ma / mb;
    r = ma % mb;
    if (neg_a ^ neg_b) q = 32'd0 - q;
    if (neg_a)         r = 32'd0 - r;
    return {r, q};
  endfunction

  // Instruction decode for the slot in E; bubbles and non-SPECIAL ops decode to nothing.
  always_comb begin
    is_r     = E_valid && (E_op == 6'b000000);
    dec_mul  = is_r && ((E_fuc == F_MULT) || (E_fuc == F_MULTU));
    dec_div  = is_r && ((E_fuc == F_DIV)  || (E_fuc == F_DIVU));
    dec_sgn  = (E_fuc == F_MULT) || (E_fuc == F_DIV);
    dec_mfhi = is_r && (E_fuc == F_MFHI);
    dec_mflo = is_r && (E_fuc == F_MFLO);
    dec_mthi = is_r && (E_fuc == F_MTHI);
    dec_mtlo = is_r && (E_fuc == F_MTLO);
    mul_res  = mul_full(E_rs_val, E_rt_val, dec_sgn);
    div_res  = div_full(E_rs_val, E_rt_val, dec_sgn);
  end

  // Handshake outputs. start is masked by reset so nothing appears to launch while reset is held.
  always_comb begin
    start    = reset && (dec_mul || dec_div) && (count_q == 4'd0);
    busy     = start || (count_q != 4'd0);
    stall    = D_md_use && busy;
    E_md_out = 32'd0;
    if (dec_mfhi)      E_md_out = hi_q;
    else if (dec_mflo) E_md_out = lo_q;
  end

  // Next state: launch, count down and commit, or accept mthi/mtlo when idle.
  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    if (start) begin
      if (dec_mul) begin
        count_d                = MULT_LD;
        {pend_hi_d, pend_lo_d} = mul_res;
        pend_ok_d              = 1'b1;
      end else begin
        count_d                = DIV_LD;
        {pend_hi_d, pend_lo_d} = div_res;
        pend_ok_d              = (E_rt_val != 32'd0);
      end
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
      if ((count_q == 4'd1) && pend_ok_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      if (dec_mthi) hi_d = E_rs_val;
      if (dec_mtlo) lo_d = E_rs_val;
    end
  end

  // State registers with synchronous active-low clear; a clear discards any in-flight op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
